// File: rtl/usb_rx_hdr_framer.sv
// Receive-side header-packet framer: strips SKP symbols, detects SHP x3 + EPF,
// packs the payload into little-endian words and queues them in a FWFT FIFO.
module usb_rx_hdr_framer #(
  parameter int FIFO_DEPTH = 8,
  parameter int HDR_BYTES  = 16
) (
  input  logic        PHY_CLK,
  input  logic        PHY_RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_DATAK,
  input  logic        RX_VALID,
  input  logic [2:0]  RX_STATUS,
  input  logic        HDR_READY,
  output logic        HDR_VALID,
  output logic [31:0] HDR_DATA,
  output logic        HDR_SOP,
  output logic        HDR_EOP,
  output logic        HDR_ERR,
  output logic [7:0]  SKP_CNT,
  output logic [7:0]  DROP_CNT,
  output logic [7:0]  ERR_CNT,
  output logic        FRAMER_BUSY
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IW    = $clog2(HDR_BYTES);
  localparam int WORDS = HDR_BYTES / 4;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC1   = 3'd1;
  localparam logic [2:0] SYNC2   = 3'd2;
  localparam logic [2:0] SYNC3   = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;

  logic [2:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_errflag;
  logic [23:0]   r_bytes;
  logic [7:0]    r_skp_cnt;
  logic [7:0]    r_drop_cnt;
  logic [7:0]    r_err_cnt;

  logic [34:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic        w_skp;
  logic        w_sym;
  logic        w_shp;
  logic        w_epf;
  logic        w_stat_err;
  logic        w_byte_err;
  logic        w_last;
  logic        w_sop;
  logic        w_word_err;
  logic        w_push;
  logic        w_pop;
  logic        w_space;
  logic [34:0] w_head;
  logic        w_unused;

  assign w_skp      = RX_VALID && RX_DATAK && (RX_DATA == 8'h3C);
  assign w_sym      = RX_VALID && !w_skp;
  assign w_shp      = RX_DATAK && (RX_DATA == 8'h5C);
  assign w_epf      = RX_DATAK && (RX_DATA == 8'hFB);
  assign w_stat_err = RX_STATUS[2];
  assign w_byte_err = w_stat_err || RX_DATAK;
  assign w_last     = (r_idx == IW'(HDR_BYTES - 1));
  assign w_sop      = (r_idx == IW'(3));
  assign w_word_err = w_last && (r_errflag || w_byte_err);
  assign w_push     = w_sym && (r_state == PAYLOAD) && (r_idx[1:0] == 2'b11);
  assign w_pop      = HDR_VALID && HDR_READY;
  assign w_unused   = ^RX_STATUS[1:0];

  // Room for a whole packet is reserved at EPF; a pop on the same edge is not credited.
  assign w_space = ({{(31 - AW){1'b0}}, r_count} + 32'(WORDS)) <= 32'(FIFO_DEPTH);

  // Framing state machine and saturating statistics.
  always_ff @(posedge PHY_CLK or posedge PHY_RST) begin
    if (PHY_RST) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_errflag  <= 1'b0;
      r_bytes    <= '0;
      r_skp_cnt  <= '0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_skp && (r_skp_cnt != 8'hFF))
        r_skp_cnt <= r_skp_cnt + 8'd1;
      if (w_sym) begin
        case (r_state)
          IDLE:  if (w_shp) r_state <= SYNC1;
          SYNC1: r_state <= (w_shp && !w_stat_err) ? SYNC2 : IDLE;
          SYNC2: r_state <= (w_shp && !w_stat_err) ? SYNC3 : IDLE;
          SYNC3: begin
            if (w_stat_err) begin
              r_state <= IDLE;
            end else if (w_shp) begin
              r_state <= SYNC3;
            end else if (w_epf) begin
              if (w_space) begin
                r_state   <= PAYLOAD;
                r_idx     <= '0;
                r_errflag <= 1'b0;
              end else begin
                r_state <= IDLE;
                if (r_drop_cnt != 8'hFF)
                  r_drop_cnt <= r_drop_cnt + 8'd1;
              end
            end else begin
              r_state <= IDLE;
            end
          end
          PAYLOAD: begin
            r_errflag <= r_errflag || w_byte_err;
            r_idx     <= r_idx + IW'(1);
            case (r_idx[1:0])
              2'd0:    r_bytes[7:0]   <= RX_DATA;
              2'd1:    r_bytes[15:8]  <= RX_DATA;
              2'd2:    r_bytes[23:16] <= RX_DATA;
              default: r_bytes        <= r_bytes;
            endcase
            if (w_last) begin
              r_state <= IDLE;
              if (w_word_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge PHY_CLK or posedge PHY_RST) begin
    if (PHY_RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge PHY_CLK) begin
    if (w_push)
      r_mem[r_wptr] <= {w_word_err, w_last, w_sop, RX_DATA, r_bytes};
  end

  // Head entry falls through; outputs are forced to zero while the FIFO is empty.
  assign w_head      = r_mem[r_rptr];
  assign HDR_VALID   = (r_count != '0);
  assign HDR_DATA    = HDR_VALID ? w_head[31:0] : 32'h0;
  assign HDR_SOP     = HDR_VALID && w_head[32];
  assign HDR_EOP     = HDR_VALID && w_head[33];
  assign HDR_ERR     = HDR_VALID && w_head[34];
  assign SKP_CNT     = r_skp_cnt;
  assign DROP_CNT    = r_drop_cnt;
  assign ERR_CNT     = r_err_cnt;
  assign FRAMER_BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_usb_rx_hdr_framer.sv
// Scoreboard bench for usb_rx_hdr_framer: expected words are queued as packets
// are driven and compared whenever the DUT hands a word over.
module tb_usb_rx_hdr_framer;

  logic        PHY_CLK;
  logic        PHY_RST;
  logic [7:0]  RX_DATA;
  logic        RX_DATAK;
  logic        RX_VALID;
  logic [2:0]  RX_STATUS;
  logic        HDR_READY;
  logic        HDR_VALID;
  logic [31:0] HDR_DATA;
  logic        HDR_SOP;
  logic        HDR_EOP;
  logic        HDR_ERR;
  logic [7:0]  SKP_CNT;
  logic [7:0]  DROP_CNT;
  logic [7:0]  ERR_CNT;
  logic        FRAMER_BUSY;

  int nChecks = 0;
  int nErrors = 0;
  int expSkp  = 0;
  int expDrop = 0;
  int expErr  = 0;
  logic [34:0] expQ [$];

  usb_rx_hdr_framer #(.FIFO_DEPTH(8), .HDR_BYTES(16)) dut (
    .PHY_CLK(PHY_CLK), .PHY_RST(PHY_RST),
    .RX_DATA(RX_DATA), .RX_DATAK(RX_DATAK), .RX_VALID(RX_VALID), .RX_STATUS(RX_STATUS),
    .HDR_READY(HDR_READY), .HDR_VALID(HDR_VALID), .HDR_DATA(HDR_DATA),
    .HDR_SOP(HDR_SOP), .HDR_EOP(HDR_EOP), .HDR_ERR(HDR_ERR),
    .SKP_CNT(SKP_CNT), .DROP_CNT(DROP_CNT), .ERR_CNT(ERR_CNT), .FRAMER_BUSY(FRAMER_BUSY)
  );

  initial begin
    PHY_CLK = 1'b0;
    forever #5 PHY_CLK = ~PHY_CLK;
  end

  // Word monitor: a transfer happens on the next rising edge when valid and ready are high.
  always begin
    logic [34:0] got;
    @(negedge PHY_CLK);
    #1;
    if (HDR_VALID && HDR_READY) begin
      got = {HDR_ERR, HDR_EOP, HDR_SOP, HDR_DATA};
      nChecks++;
      if (expQ.size() == 0) begin
        nErrors++;
        $display("[TB] FAIL word_unexpected got %h expected none", got);
      end else if (got !== expQ[0]) begin
        nErrors++;
        $display("[TB] FAIL word got %h expected %h", got, expQ[0]);
        void'(expQ.pop_front());
      end else begin
        void'(expQ.pop_front());
      end
    end
  end

  task automatic sendByte(input logic [7:0] d, input logic k, input logic [2:0] st);
    RX_DATA   = d;
    RX_DATAK  = k;
    RX_STATUS = st;
    RX_VALID  = 1'b1;
    @(posedge PHY_CLK);
    @(negedge PHY_CLK);
    RX_VALID  = 1'b0;
    RX_DATAK  = 1'b0;
    RX_STATUS = 3'b000;
  endtask

  task automatic doReset();
    PHY_RST = 1'b1;
    @(negedge PHY_CLK);
    @(negedge PHY_CLK);
    PHY_RST = 1'b0;
    expQ.delete();
    expSkp  = 0;
    expDrop = 0;
    expErr  = 0;
    @(negedge PHY_CLK);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || HDR_VALID) && n < 100) begin
      @(negedge PHY_CLK);
      n++;
    end
  endtask

  // Drives SHP SHP [SKP] SHP EPF and nBytes payload bytes base, base+1, ...
  task automatic sendPacket(input logic [7:0] base, input int errIdx, input bit withSkp,
                            input bit stored, input int nBytes, input bit checkLat);
    logic [7:0]  b;
    logic [31:0] w;
    bit          perr;
    perr = (errIdx >= 0) && (errIdx < 16);
    if (stored) begin
      for (int wi = 0; wi < 4; wi++) begin
        if (4 * wi + 3 < nBytes) begin
          for (int k = 0; k < 4; k++) begin
            b = base + 8'(4 * wi + k);
            w[8*k +: 8] = b;
          end
          expQ.push_back({(wi == 3) && perr, wi == 3, wi == 0, w});
        end
      end
      if (perr && nBytes == 16) expErr++;
    end else begin
      expDrop++;
    end
    sendByte(8'h5C, 1'b1, 3'b000);
    if (checkLat) begin
      nChecks++;
      if (FRAMER_BUSY !== 1'b1) begin
        nErrors++;
        $display("[TB] FAIL busy_after_shp got %b expected 1", FRAMER_BUSY);
      end
    end
    sendByte(8'h5C, 1'b1, 3'b000);
    if (withSkp) begin
      sendByte(8'h3C, 1'b1, 3'b100);
      expSkp++;
    end
    sendByte(8'h5C, 1'b1, 3'b000);
    sendByte(8'hFB, 1'b1, 3'b000);
    for (int i = 0; i < nBytes; i++) begin
      b = base + 8'(i);
      sendByte(b, 1'b0, (i == errIdx) ? 3'b100 : 3'b000);
      if (checkLat && i == 2) begin
        nChecks++;
        if (HDR_VALID !== 1'b0) begin
          nErrors++;
          $display("[TB] FAIL latency_early got %b expected 0", HDR_VALID);
        end
      end
      if (checkLat && i == 3) begin
        nChecks++;
        if (HDR_VALID !== 1'b1) begin
          nErrors++;
          $display("[TB] FAIL latency_first_word got %b expected 1", HDR_VALID);
        end
      end
      if (withSkp && i == 5) begin
        sendByte(8'h3C, 1'b1, 3'b000);
        expSkp++;
      end
      if (withSkp && i == 9) @(negedge PHY_CLK);
    end
    if (checkLat && nBytes == 16) begin
      nChecks++;
      if (FRAMER_BUSY !== 1'b0) begin
        nErrors++;
        $display("[TB] FAIL busy_after_last got %b expected 0", FRAMER_BUSY);
      end
    end
  endtask

  task automatic test_reset();
    PHY_RST = 1'b1;
    @(negedge PHY_CLK);
    nChecks++;
    if ({HDR_VALID, HDR_DATA, HDR_SOP, HDR_EOP, HDR_ERR, FRAMER_BUSY} !== 37'h0) begin
      nErrors++;
      $display("[TB] FAIL reset_outputs got %h expected 0",
               {HDR_VALID, HDR_DATA, HDR_SOP, HDR_EOP, HDR_ERR, FRAMER_BUSY});
    end
    nChecks++;
    if ({SKP_CNT, DROP_CNT, ERR_CNT} !== 24'h0) begin
      nErrors++;
      $display("[TB] FAIL reset_counters got %h expected 000000", {SKP_CNT, DROP_CNT, ERR_CNT});
    end
    doReset();
  endtask

  task automatic test_clean();
    $display("[TB] clean packet");
    doReset();
    HDR_READY = 1'b1;
    sendPacket(8'h00, -1, 1'b0, 1'b1, 16, 1'b1);
    waitDrain();
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL clean_drain got %0d pending expected 0", expQ.size());
    end
    nChecks++;
    if ({SKP_CNT, DROP_CNT, ERR_CNT} !== 24'h0) begin
      nErrors++;
      $display("[TB] FAIL clean_counters got %h expected 000000", {SKP_CNT, DROP_CNT, ERR_CNT});
    end
  endtask

  task automatic test_skp();
    $display("[TB] SKP removal");
    sendPacket(8'h00, -1, 1'b1, 1'b1, 16, 1'b0);
    waitDrain();
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL skp_drain got %0d pending expected 0", expQ.size());
    end
    nChecks++;
    if (SKP_CNT !== 8'(expSkp)) begin
      nErrors++;
      $display("[TB] FAIL skp_cnt got %0d expected %0d", SKP_CNT, expSkp);
    end
  endtask

  task automatic test_error();
    $display("[TB] status error on byte 9");
    sendPacket(8'h00, 9, 1'b0, 1'b1, 16, 1'b0);
    waitDrain();
    nChecks++;
    if (ERR_CNT !== 8'(expErr)) begin
      nErrors++;
      $display("[TB] FAIL err_cnt got %0d expected %0d", ERR_CNT, expErr);
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL err_drain got %0d pending expected 0", expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    $display("[TB] back-to-back with stalled consumer");
    doReset();
    HDR_READY = 1'b0;
    sendPacket(8'h10, -1, 1'b0, 1'b1, 16, 1'b0);
    sendPacket(8'h40, -1, 1'b0, 1'b1, 16, 1'b0);
    sendPacket(8'h80, -1, 1'b0, 1'b0, 16, 1'b0);
    nChecks++;
    if (DROP_CNT !== 8'(expDrop)) begin
      nErrors++;
      $display("[TB] FAIL drop_cnt got %0d expected %0d", DROP_CNT, expDrop);
    end
    nChecks++;
    if ({HDR_VALID, HDR_SOP, HDR_DATA} !== {2'b11, 32'h13121110}) begin
      nErrors++;
      $display("[TB] FAIL held_head got %h expected 313121110", {HDR_VALID, HDR_SOP, HDR_DATA});
    end
    HDR_READY = 1'b1;
    n = 0;
    while (HDR_VALID && n < 20) begin
      @(negedge PHY_CLK);
      n++;
    end
    nChecks++;
    if (n != 8) begin
      nErrors++;
      $display("[TB] FAIL drain_cycles got %0d expected 8", n);
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL b2b_drain got %0d pending expected 0", expQ.size());
    end
  endtask

  task automatic test_broken_sync();
    $display("[TB] broken sync then clean packet");
    doReset();
    sendByte(8'h5C, 1'b1, 3'b000);
    sendByte(8'h5C, 1'b1, 3'b000);
    sendByte(8'h00, 1'b0, 3'b000);
    sendByte(8'hFB, 1'b1, 3'b000);
    for (int i = 0; i < 16; i++) sendByte(8'hA0 + 8'(i), 1'b0, 3'b000);
    nChecks++;
    if ({HDR_VALID, FRAMER_BUSY} !== 2'b00) begin
      nErrors++;
      $display("[TB] FAIL broken_no_output got %b expected 00", {HDR_VALID, FRAMER_BUSY});
    end
    sendPacket(8'hC0, -1, 1'b0, 1'b1, 16, 1'b0);
    waitDrain();
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL broken_drain got %0d pending expected 0", expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset mid-packet");
    doReset();
    HDR_READY = 1'b0;
    sendPacket(8'h20, -1, 1'b1, 1'b1, 6, 1'b0);
    PHY_RST = 1'b1;
    expQ.delete();
    expSkp = 0;
    @(negedge PHY_CLK);
    nChecks++;
    if ({HDR_VALID, HDR_DATA, HDR_SOP, HDR_EOP, HDR_ERR, FRAMER_BUSY} !== 37'h0) begin
      nErrors++;
      $display("[TB] FAIL midreset_outputs got %h expected 0",
               {HDR_VALID, HDR_DATA, HDR_SOP, HDR_EOP, HDR_ERR, FRAMER_BUSY});
    end
    nChecks++;
    if (SKP_CNT !== 8'h00) begin
      nErrors++;
      $display("[TB] FAIL midreset_skp got %0d expected 0", SKP_CNT);
    end
    PHY_RST = 1'b0;
    HDR_READY = 1'b1;
    @(negedge PHY_CLK);
    sendPacket(8'h30, -1, 1'b0, 1'b1, 16, 1'b1);
    waitDrain();
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++;
      $display("[TB] FAIL midreset_drain got %0d pending expected 0", expQ.size());
    end
  endtask

  initial begin
    PHY_RST   = 1'b1;
    RX_DATA   = 8'h00;
    RX_DATAK  = 1'b0;
    RX_VALID  = 1'b0;
    RX_STATUS = 3'b000;
    HDR_READY = 1'b1;
    test_reset();
    test_clean();
    test_skp();
    test_error();
    test_back_to_back();
    test_broken_sync();
    test_reset_mid();
    repeat (4) @(negedge PHY_CLK);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/usb_rx_hdr_framer.md
# usb_rx_hdr_framer

Receive-side link-layer framer sitting directly downstream of `usb_phy`. It consumes the PIPE receive byte stream (`RX_DATA`, `RX_DATAK`, `RX_VALID`, `RX_STATUS`) and discards SKP symbols. It detects the header-packet start sequence, assembles the 16-byte header packet into four little-endian 32-bit words and buffers them in a word FIFO. The FIFO feeds the link-layer header processor through a valid/ready handshake.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: word FIFO entries; power of two, ≥ 4.
- `HDR_BYTES`, 16: payload bytes per header packet; multiple of 4.

Ports:
- `PHY_CLK` in 1: single clock, rising edge; same clock as `PHY_PCLK` domain output of `usb_phy`.
- `PHY_RST` in 1: reset, asynchronous, active-high.
- `RX_DATA` in 8: received byte.
- `RX_DATAK` in 1: 1 = `RX_DATA` is a K symbol.
- `RX_VALID` in 1: byte qualifier; byte is ignored when 0.
- `RX_STATUS` in 3: PIPE status; any value `1xx` is a receive error.
- `HDR_READY` in 1: consumer accepts the current word.
- `HDR_VALID` out 1: FIFO non-empty; word presented.
- `HDR_DATA` out 32: header word; first received byte in `[7:0]`.
- `HDR_SOP` out 1: first word of a packet.
- `HDR_EOP` out 1: last word of a packet.
- `HDR_ERR` out 1: valid only with `HDR_EOP`; packet saw an error.
- `SKP_CNT` out 8: SKP symbols removed, saturating.
- `DROP_CNT` out 8: packets dropped for lack of FIFO space, saturating.
- `ERR_CNT` out 8: packets delivered with `HDR_ERR`, saturating.
- `FRAMER_BUSY` out 1: state ≠ IDLE.

## Operation

- Symbol constants:
  - SHP = K28.2 (`5C`, K=1).
  - EPF = K27.7 (`FB`, K=1).
  - SKP = K28.1 (`3C`, K=1).
- A symbol is "taken" on a rising edge with `RX_VALID`=1. Nothing advances when `RX_VALID`=0.
- SKP handling, in every state:
  - A taken SKP is discarded and `SKP_CNT` increments.
  - It does not change state or byte position.
  - SKP `RX_STATUS` is ignored.
- States: IDLE, SYNC1, SYNC2, SYNC3, PAYLOAD.
  - IDLE: SHP → SYNC1; anything else stays in IDLE.
  - SYNC1: SHP → SYNC2; other → IDLE.
  - SYNC2: SHP → SYNC3; other → IDLE.
  - SYNC3: SHP → stay in SYNC3. EPF → if FIFO free entries (`FIFO_DEPTH` − count, same-cycle pop ignored) ≥ `HDR_BYTES`/4, go to PAYLOAD, clear the byte index and error flag; else go to IDLE and increment `DROP_CNT`. Other → IDLE.
  - Any sync state with an error `RX_STATUS` → IDLE.
  - PAYLOAD: every taken non-SKP symbol is a payload byte at index i.
    - Error flag is set if `RX_STATUS`=`1xx` or `RX_DATAK`=1 (the byte is still stored).
    - When i%4 = 3, one FIFO entry is written on that edge: {data, SOP = (i==3), EOP = (i==`HDR_BYTES`−1), ERR = flag incl. current byte when EOP}.
    - After index `HDR_BYTES`−1 → IDLE. `ERR_CNT` increments if ERR=1.
- Space is reserved at EPF, so the FIFO never overflows mid-packet.
- FIFO is first-word-fall-through. Pop occurs when `HDR_VALID`&&`HDR_READY`. Simultaneous push and pop are allowed at any count, including full-with-pop.
- All counters saturate at 255 and clear only on reset.

## Timing

- Reset values: `HDR_VALID`, `HDR_DATA`, `HDR_SOP`, `HDR_EOP`, `HDR_ERR`, all counters and `FRAMER_BUSY` are 0. FIFO is empty and state is IDLE.
- Reset asserted mid-packet aborts immediately; partial words are lost.
- Latency: a word is written on the edge its 4th byte is taken. `HDR_VALID` and the word appear the following cycle when the FIFO was empty.
- `HDR_DATA`/flags are held stable while `HDR_VALID`=1 and `HDR_READY`=0.
- Counter updates are visible the cycle after the causing symbol.
- `FRAMER_BUSY` is high from the cycle after the first SHP until the cycle after the last payload byte.
- Sustained rate: one byte per cycle in; one word per cycle out.

## Test plan

- Clean packet `5C 5C 5C FB` (K), then bytes `00`..`0F` with `HDR_READY`=1 → words `03020100` (SOP), `07060504`, `0B0A0908`, `0F0E0D0C` (EOP, ERR=0); first `HDR_VALID` one cycle after byte `03`.
- Same packet with SKP `3C` inserted after the 2nd SHP and after byte `05`, plus one `RX_VALID`=0 gap → identical words; `SKP_CNT`=2.
- `RX_STATUS`=`100` on byte `09` → four words delivered; EOP word `HDR_ERR`=1; `ERR_CNT`=1.
- `HDR_READY`=0, three back-to-back packets, `FIFO_DEPTH`=8 → 8 words stored, third packet dropped, `DROP_CNT`=1. Then `HDR_READY`=1 → 8 words drain in 8 cycles, in order.
- Broken sync `5C 5C 00 FB` followed by a clean packet → no output for the first; second packet delivered intact.
- `PHY_RST` pulsed after 6 payload bytes → all outputs 0 next cycle; the next clean packet is delivered correctly.
